// File: rtl/apb_pkg.sv
// Shared types and register map for the APB requester and its clients.
package apb_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;

  localparam logic [31:0] APB_ADDR_TX  = 32'h0;
  localparam logic [31:0] APB_ADDR_RX  = 32'h4;
  localparam logic [31:0] APB_ADDR_CFG = 32'h8;
  localparam logic [31:0] APB_ADDR_TMO = 32'hC;

  // One spare bit so a disabled (0) timeout still yields a legal width.
  function automatic int unsigned cnt_width(input int unsigned t);
    return $clog2(t) + 1;
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS wait-state counter: clear on SETUP, count PREADY=0 cycles, flag the last allowed cycle.
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic PCLK,
  input  logic PRESET,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int unsigned CW   = cnt_width(TIMEOUT_CYCLES);
  localparam int unsigned TMAX = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  logic [CW-1:0] cnt;

  // Saturates rather than wraps so a disabled timeout can never fire spuriously.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)                 cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (inc && cnt != '1)  cnt <= cnt + CW'(1);
  end

  assign expired = (TIMEOUT_CYCLES != 0) && (cnt == CW'(TMAX));

endmodule

// File: rtl/apb_master.sv
// APB requester: one command in, one SETUP/ACCESS transfer out, one response pulse back.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_WRITE,
  input  logic [ADDR_W-1:0] CMD_ADDR,
  input  logic [DATA_W-1:0] CMD_WDATA,
  output logic              RSP_VALID,
  output logic [DATA_W-1:0] RSP_RDATA,
  output logic              RSP_ERR,
  output logic              RSP_TIMEOUT,
  output logic              PSELx,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  apb_state_t        state_q, state_d;
  logic              psel_d, pen_d, pwrite_d;
  logic [ADDR_W-1:0] paddr_d;
  logic [DATA_W-1:0] pwdata_d;
  logic              rv_d, err_d, tmo_d;
  logic [DATA_W-1:0] rd_d;
  logic              tmr_clr, tmr_inc, tmr_exp;

  apb_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .clr     (tmr_clr),
    .inc     (tmr_inc),
    .expired (tmr_exp)
  );

  assign CMD_READY = (state_q == IDLE) && !PRESET;

  always_comb begin
    state_d  = state_q;
    psel_d   = PSELx;
    pen_d    = PENABLE;
    pwrite_d = PWRITE;
    paddr_d  = PADDR;
    pwdata_d = PWDATA;
    rv_d     = 1'b0;
    rd_d     = '0;
    err_d    = 1'b0;
    tmo_d    = 1'b0;
    tmr_clr  = 1'b0;
    tmr_inc  = 1'b0;
    unique case (state_q)
      IDLE: if (CMD_VALID) begin
        pwrite_d = CMD_WRITE;
        paddr_d  = CMD_ADDR;
        pwdata_d = CMD_WDATA;
        psel_d   = 1'b1;
        pen_d    = 1'b0;
        state_d  = SETUP;
      end
      SETUP: begin
        pen_d   = 1'b1;
        tmr_clr = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        // Completion is checked first so a ready on the last allowed cycle is not a timeout.
        if (PREADY) begin
          psel_d  = 1'b0;
          pen_d   = 1'b0;
          rv_d    = 1'b1;
          err_d   = PSLVERR;
          rd_d    = PWRITE ? '0 : PRDATA;
          state_d = IDLE;
        end else if (tmr_exp) begin
          psel_d  = 1'b0;
          pen_d   = 1'b0;
          rv_d    = 1'b1;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= IDLE;
      PSELx       <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      RSP_VALID   <= 1'b0;
      RSP_RDATA   <= '0;
      RSP_ERR     <= 1'b0;
      RSP_TIMEOUT <= 1'b0;
    end else begin
      state_q     <= state_d;
      PSELx       <= psel_d;
      PENABLE     <= pen_d;
      PWRITE      <= pwrite_d;
      PADDR       <= paddr_d;
      PWDATA      <= pwdata_d;
      RSP_VALID   <= rv_d;
      RSP_RDATA   <= rd_d;
      RSP_ERR     <= err_d;
      RSP_TIMEOUT <= tmo_d;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench: reactive APB completer, per-cycle timeline model, literal spot checks.
module tb_apb_master;
  import apb_pkg::*;

  localparam int TMO  = 16;
  localparam int MAXC = 600;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        CMD_VALID = 1'b0, CMD_WRITE = 1'b0;
  logic [31:0] CMD_ADDR = '0, CMD_WDATA = '0;
  logic        CMD_READY, RSP_VALID, RSP_ERR, RSP_TIMEOUT;
  logic [31:0] RSP_RDATA;
  logic        PSELx, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b0, PSLVERR = 1'b0;

  apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR), .RSP_TIMEOUT(RSP_TIMEOUT),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int total = 0, bad = 0;
  int cyc = 0;
  always @(posedge PCLK) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // Expected output timeline, one slot per cycle (cycle c = interval after the c-th rising edge).
  bit        e_psel[MAXC], e_pen[MAXC], e_pwrite[MAXC], e_rv[MAXC], e_err[MAXC], e_tmo[MAXC];
  bit [31:0] e_paddr[MAXC], e_pwdata[MAXC], e_rd[MAXC];
  bit [31:0] mdl_regs[4];

  // Handshake in cycle t: SETUP in t+1, n ACCESS cycles, response right after.
  function automatic int plan(input int t, input bit wr, input bit [31:0] a, input bit [31:0] d,
                              input int w, input bit e);
    bit tmo = (w >= TMO);
    int n   = tmo ? TMO : w + 1;
    int r   = t + 2 + n;
    for (int c = t + 1; c < MAXC; c++) begin
      e_pwrite[c] = wr; e_paddr[c] = a; e_pwdata[c] = d;
    end
    e_psel[t+1] = 1'b1;
    for (int k = 0; k < n; k++) begin e_psel[t+2+k] = 1'b1; e_pen[t+2+k] = 1'b1; end
    e_rv[r]  = 1'b1;
    e_err[r] = tmo | e;
    e_tmo[r] = tmo;
    e_rd[r]  = (tmo || wr) ? 32'h0 : mdl_regs[a[3:2]];
    if (wr && !tmo && !e) mdl_regs[a[3:2]] = d;
    return r;
  endfunction

  task automatic clear_from(input int c);
    for (int i = c; i < MAXC; i++) begin
      e_psel[i] = 0; e_pen[i] = 0; e_pwrite[i] = 0; e_rv[i] = 0; e_err[i] = 0; e_tmo[i] = 0;
      e_paddr[i] = 0; e_pwdata[i] = 0; e_rd[i] = 0;
    end
  endtask

  always @(negedge PCLK) if (cyc < MAXC) begin
    chk("cmd_ready", CMD_READY, !e_psel[cyc] && !PRESET);
    chk("psel", PSELx, e_psel[cyc]);
    chk("penable", PENABLE, e_pen[cyc]);
    chk("pwrite", PWRITE, e_pwrite[cyc]);
    chk("paddr", PADDR, e_paddr[cyc]);
    chk("pwdata", PWDATA, e_pwdata[cyc]);
    chk("rsp_valid", RSP_VALID, e_rv[cyc]);
    chk("rsp_rdata", RSP_RDATA, e_rd[cyc]);
    chk("rsp_err", RSP_ERR, e_err[cyc]);
    chk("rsp_timeout", RSP_TIMEOUT, e_tmo[cyc]);
  end

  // Observers feeding the literal spot checks.
  int psel_cnt = 0, pen_cnt = 0, rsp_cnt = 0, ovl_cnt = 0, rsp_cyc = 0;
  bit [31:0] last_rd;
  bit last_err, last_tmo;
  int acc_q[$];
  always @(negedge PCLK) begin
    if (PSELx) psel_cnt++;
    if (PENABLE) pen_cnt++;
    if (RSP_VALID) begin
      rsp_cnt++; rsp_cyc = cyc; last_rd = RSP_RDATA; last_err = RSP_ERR; last_tmo = RSP_TIMEOUT;
    end
    if (CMD_VALID && CMD_READY) begin
      acc_q.push_back(cyc);
      if (RSP_VALID) ovl_cnt++;
    end
  end

  // Reactive completer: ready after cur_waits stall cycles; PSLVERR is junk-high while stalled.
  int cur_waits = 0;
  bit cur_err = 0;
  int acc = 0;
  bit [31:0] dev_regs[4];
  always @(posedge PCLK) begin
    if (!PRESET && PSELx && PENABLE && PREADY && PWRITE && !PSLVERR) dev_regs[PADDR[3:2]] = PWDATA;
    #1;
    if (PSELx && !PENABLE) acc = 0;
    else if (PSELx && PENABLE) acc++;
    PREADY  = PSELx && PENABLE && (acc == cur_waits + 1);
    PRDATA  = PREADY ? dev_regs[PADDR[3:2]] : 32'hBAD0BAD0;
    PSLVERR = PREADY ? cur_err : (PSELx && PENABLE);
  end

  task automatic step();
    @(posedge PCLK); #1;
  endtask

  task automatic start(input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input int w, input bit e, output int r);
    cur_waits = w; cur_err = e;
    CMD_VALID = 1'b1; CMD_WRITE = wr; CMD_ADDR = a; CMD_WDATA = d;
    r = plan(cyc, wr, a, d, w, e);
  endtask

  task automatic wait_until(input int r);
    while (cyc < r) step();
  endtask

  task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input int w, input bit e);
    int r;
    psel_cnt = 0; pen_cnt = 0;
    start(wr, a, d, w, e, r);
    step();
    CMD_VALID = 1'b0; CMD_ADDR = 32'hFFFF_FFF0; CMD_WDATA = 32'hFFFF_FFFF;
    wait_until(r);
    step();
  endtask

  initial begin
    int r0, r1, r2, a0, rc;
    dev_regs[1] = 32'hDEADBEEF; mdl_regs[1] = 32'hDEADBEEF;
    dev_regs[3] = 32'h0000C0DE; mdl_regs[3] = 32'h0000C0DE;
    #3;
    chk("rst_psel", PSELx, 1'b0);
    chk("rst_ready", CMD_READY, 1'b0);
    chk("rst_rsp", RSP_VALID, 1'b0);
    step(); step();
    PRESET = 1'b0;
    step();

    // 1: zero-wait CONFIG write, then read it back.
    a0 = acc_q.size();
    issue(1, APB_ADDR_CFG, 32'h1234, 0, 0);
    chk("t1_psel_cycles", psel_cnt, 2);
    chk("t1_pen_cycles", pen_cnt, 1);
    chk("t1_latency", rsp_cyc - acc_q[a0], 3);
    chk("t1_err", last_err, 0);
    chk("t1_rdata", last_rd, 0);
    chk("t1_dev_cfg", dev_regs[2], 32'h1234);
    issue(0, APB_ADDR_CFG, 0, 0, 0);
    chk("t1_readback", last_rd, 32'h1234);

    // 2: RX read with 3 stall cycles.
    issue(0, APB_ADDR_RX, 0, 3, 0);
    chk("t2_access_cycles", pen_cnt, 4);
    chk("t2_rdata", last_rd, 32'hDEADBEEF);
    chk("t2_err", last_err, 0);

    // 3: slave error on TX write.
    issue(1, APB_ADDR_TX, 32'hAA55, 0, 1);
    chk("t3_err", last_err, 1);
    chk("t3_tmo", last_tmo, 0);

    // 4: completer never ready.
    issue(0, APB_ADDR_CFG, 0, 100, 0);
    chk("t4_access_cycles", pen_cnt, TMO);
    chk("t4_err", last_err, 1);
    chk("t4_tmo", last_tmo, 1);
    chk("t4_rdata", last_rd, 0);

    // Ready on the very last allowed cycle completes normally.
    issue(0, APB_ADDR_RX, 0, TMO - 1, 0);
    chk("t4b_tmo", last_tmo, 0);
    chk("t4b_rdata", last_rd, 32'hDEADBEEF);

    // 5: reset in the middle of ACCESS.
    rc = rsp_cnt;
    start(0, APB_ADDR_RX, 0, 5, 0, r0);
    step();
    CMD_VALID = 1'b0;
    step(); step();
    #2 PRESET = 1'b1;
    #1;
    clear_from(cyc);
    chk("t5_psel", PSELx, 0);
    chk("t5_pen", PENABLE, 0);
    chk("t5_paddr", PADDR, 0);
    chk("t5_ready", CMD_READY, 0);
    step(); step();
    PRESET = 1'b0;
    step(); step(); step(); step(); step(); step();
    chk("t5_no_rsp", rsp_cnt, rc);
    issue(0, APB_ADDR_TMO, 0, 1, 0);
    chk("t5_fresh_read", last_rd, 32'h0000C0DE);

    // 6: back-to-back, CMD_VALID held with junk between accepts.
    a0 = acc_q.size(); rc = ovl_cnt;
    start(1, APB_ADDR_TX, 32'h11, 0, 0, r0);
    step();
    CMD_WRITE = 1'b1; CMD_ADDR = 32'hFFFF_FFF0; CMD_WDATA = 32'hFFFF_FFFF;
    wait_until(r0);
    start(1, APB_ADDR_RX, 32'h22, 0, 0, r1);
    step();
    CMD_WRITE = 1'b1; CMD_ADDR = 32'hFFFF_FFF0; CMD_WDATA = 32'hFFFF_FFFF;
    wait_until(r1);
    start(0, APB_ADDR_TX, 0, 0, 0, r2);
    step();
    CMD_VALID = 1'b0;
    wait_until(r2);
    step();
    chk("t6_accepts", acc_q.size() - a0, 3);
    chk("t6_gap01", acc_q[a0+1] - acc_q[a0], 3);
    chk("t6_gap12", acc_q[a0+2] - acc_q[a0+1], 3);
    chk("t6_accept_in_rsp", ovl_cnt - rc, 2);
    chk("t6_read_tx", last_rd, 32'h11);

    step(); step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1);
  end

endmodule
